// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package sseg_pkg;

  typedef enum logic {SHOW, DEAD} scan_state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [3:0]  AN_OFF     = 4'b1111;

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
    return v[{i, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sseg_refresh_tick.sv
// Slot timer: counts REFRESH_DIV lit cycles, then DEAD_CYCLES blank cycles, one shared counter.
module sseg_refresh_tick #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic dead,
  output logic slot_end,
  output logic dead_end
);

  localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] SlotLast = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DeadLast = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end = !dead && (cnt_q == SlotLast);
    dead_end = dead && (cnt_q == DeadLast);
    cnt_d    = (slot_end || dead_end) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// Four-digit common-anode scan driver with dead time between digits.
// Optional leading-zero blanking when SSEG_SCAN_BLANK_EN is defined.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic [3:0]  binary,
  output logic [3:0]  an,
  output logic        dp
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);

  scan_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   value_q;
  logic [3:0]    dp_q;
  logic          slot_end, dead_end;
  logic          blank;
  logic [3:0]    an_d, binary_d;
  logic          dp_d;

  sseg_refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_tick (
    .clk      (clk),
    .reset    (reset),
    .dead     (state_q == DEAD),
    .slot_end (slot_end),
    .dead_end (dead_end)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      SHOW: begin
        if (slot_end) begin
          idx_d   = idx_q + 2'd1;
          state_d = (DEAD_CYCLES > 0) ? DEAD : SHOW;
        end
      end
      DEAD: begin
        if (dead_end) state_d = SHOW;
      end
    endcase
  end

`ifdef SSEG_SCAN_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  assign blank = (idx_q != 2'd0) && ((value_q >> {idx_q, 2'b00}) == 16'h0000);
`else
  assign blank = 1'b0;
`endif

  // Binary follows idx even in DEAD so the decoder settles before the anode turns on.
  always_comb begin
    an_d     = AN_OFF;
    dp_d     = 1'b1;
    binary_d = nibble_sel(value_q, idx_q);
    if (state_q == SHOW && !blank) begin
      an_d = ~(4'b0001 << idx_q);
      dp_d = ~dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SHOW;
      idx_q   <= '0;
      value_q <= '0;
      dp_q    <= '0;
      an      <= AN_OFF;
      dp      <= 1'b1;
      binary  <= 4'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) begin
        value_q <= value;
        dp_q    <= dp_in;
      end
      an      <= an_d;
      dp      <= dp_d;
      binary  <= binary_d;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Scoreboard bench for sseg_scan_mux with REFRESH_DIV=4, DEAD_CYCLES=1.
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  binary;
  logic [3:0]  an;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  logic [8:0] exp_q[$];

`ifdef SSEG_SCAN_BLANK_EN
  localparam logic [3:0] AnD2 = 4'b1111;
  localparam logic [3:0] AnD3 = 4'b1111;
`else
  localparam logic [3:0] AnD2 = 4'b1011;
  localparam logic [3:0] AnD3 = 4'b0111;
`endif

  sseg_scan_mux #(
    .REFRESH_DIV (4),
    .DEAD_CYCLES (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .value  (value),
    .dp_in  (dp_in),
    .binary (binary),
    .an     (an),
    .dp     (dp)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the coming edge.
  task automatic step(input logic r, input logic l, input logic [15:0] v, input logic [3:0] d,
                      input logic [3:0] ea, input logic [3:0] eb, input logic edp);
    @(negedge clk);
    reset = r;
    load  = l;
    value = v;
    dp_in = d;
    exp_q.push_back({ea, eb, edp});
  endtask

  task automatic idle(input int n, input logic [3:0] ea, input logic [3:0] eb, input logic edp);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 4'h0, ea, eb, edp);
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      step_no++;
      checks++;
      if ({an, binary, dp} !== e) begin
        errors++;
        $display("FAIL outputs step %0d: got an=%b binary=%h dp=%b, want an=%b binary=%h dp=%b",
                 step_no, an, binary, dp, e[8:5], e[4:1], e[0]);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot_an step %0d: got an=%b, want at most one low bit", step_no, an);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got no end of stimulus, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Reset, then load 1234 with no decimal points.
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'b1111, 4'h0, 1'b1);
    step(1'b1, 1'b0, 16'h0, 4'h0, 4'b1111, 4'h0, 1'b1);
    step(1'b0, 1'b1, 16'h1234, 4'h0, 4'b1110, 4'h0, 1'b1);
    idle(3, 4'b1110, 4'h4, 1'b1);
    idle(1, 4'b1111, 4'h3, 1'b1);
    idle(4, 4'b1101, 4'h3, 1'b1);
    idle(1, 4'b1111, 4'h2, 1'b1);
    idle(4, 4'b1011, 4'h2, 1'b1);
    idle(1, 4'b1111, 4'h1, 1'b1);
    idle(4, 4'b0111, 4'h1, 1'b1);
    idle(1, 4'b1111, 4'h4, 1'b1);
    idle(4, 4'b1110, 4'h4, 1'b1);
    idle(1, 4'b1111, 4'h3, 1'b1);
    // Load ABCD mid-slot while digit 1 is lit; slot length unchanged.
    idle(1, 4'b1101, 4'h3, 1'b1);
    step(1'b0, 1'b1, 16'hABCD, 4'h0, 4'b1101, 4'h3, 1'b1);
    idle(2, 4'b1101, 4'hC, 1'b1);
    idle(1, 4'b1111, 4'hB, 1'b1);
    // Decimal point on digit 2 only.
    step(1'b0, 1'b1, 16'hABCD, 4'b0100, 4'b1011, 4'hB, 1'b1);
    idle(3, 4'b1011, 4'hB, 1'b0);
    idle(1, 4'b1111, 4'hA, 1'b1);
    idle(4, 4'b0111, 4'hA, 1'b1);
    idle(1, 4'b1111, 4'hD, 1'b1);
    idle(4, 4'b1110, 4'hD, 1'b1);
    idle(1, 4'b1111, 4'hC, 1'b1);
    idle(4, 4'b1101, 4'hC, 1'b1);
    idle(1, 4'b1111, 4'hB, 1'b1);
    idle(1, 4'b1011, 4'hB, 1'b0);
    // Reset mid-slot with a concurrent load: reset wins, digit 0 gets a full slot.
    step(1'b1, 1'b1, 16'hFFFF, 4'hF, 4'b1111, 4'h0, 1'b1);
    idle(4, 4'b1110, 4'h0, 1'b1);
    idle(1, 4'b1111, 4'h0, 1'b1);
    // Load 0050 at the start of digit 1; digits 3 and 2 are leading zeros.
    step(1'b0, 1'b1, 16'h0050, 4'h0, 4'b1101, 4'h0, 1'b1);
    idle(3, 4'b1101, 4'h5, 1'b1);
    idle(1, 4'b1111, 4'h0, 1'b1);
    idle(4, AnD2, 4'h0, 1'b1);
    idle(1, 4'b1111, 4'h0, 1'b1);
    idle(4, AnD3, 4'h0, 1'b1);
    idle(1, 4'b1111, 4'h0, 1'b1);
    idle(4, 4'b1110, 4'h0, 1'b1);
    idle(1, 4'b1111, 4'h5, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
